// File: rtl/s2p16_deser.sv
// Framed serial-to-parallel deserializer: assembles SYNC-marked bit streams into
// WIDTH-bit words, holds the last complete word and flags premature SYNCs.
//
// state | meaning
// IDLE  | hunting for SYNC, no partial word
// SHIFT | word partially assembled, cnt_q bits received
module s2p16_deser #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int WIDTH     = 16
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             SDI,
    input  logic             SVALID,
    input  logic             SYNC,
    output logic [WIDTH-1:0] WORD,
    output logic             WVALID,
    output logic             FERR,
    output logic             BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               wvalid_q, wvalid_d;
    logic               ferr_q, ferr_d;
    logic [WIDTH-1:0]   shifted;

    // Bit order only changes the shift direction; the first bit always ends
    // up at the far end of the word after WIDTH shifts.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        word_d   = word_q;
        wvalid_d = 1'b0;
        ferr_d   = ferr_q;
        shifted  = shift_in(sreg_q, SDI);

        if (SVALID) begin
            if (SYNC) begin
                // A SYNC inside a word drops the partial word; the SYNC bit starts a new one.
                if (state_q == SHIFT)
                    ferr_d = 1'b1;
                sreg_d  = shift_in('0, SDI);
                cnt_d   = 5'd1;
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q == 5'(WIDTH - 1)) begin
                    word_d   = shifted;
                    wvalid_d = 1'b1;
                    sreg_d   = shifted;
                    cnt_d    = 5'd0;
                    state_d  = IDLE;
                end else begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            sreg_q   <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign WORD   = word_q;
    assign WVALID = wvalid_q;
    assign FERR   = ferr_q;
    assign BUSY   = (state_q == SHIFT);

endmodule

// File: tb/tb_s2p16_deser.sv
// Bench for s2p16_deser: MSB-first and LSB-first builds side by side, driven with
// directed and random framed streams and compared every cycle against a bit-queue model.
module tb_s2p16_deser;

    logic        CK = 1'b0;
    logic        RSTN = 1'b0;
    logic        SDI = 1'b0;
    logic        SVALID = 1'b0;
    logic        SYNC = 1'b0;
    logic [15:0] word_m, word_l;
    logic        wvalid_m, wvalid_l, ferr_m, ferr_l, busy_m, busy_l;

    s2p16_deser #(.MSB_FIRST(1'b1), .WIDTH(16)) u_msb (
        .CK(CK), .RSTN(RSTN), .SDI(SDI), .SVALID(SVALID), .SYNC(SYNC),
        .WORD(word_m), .WVALID(wvalid_m), .FERR(ferr_m), .BUSY(busy_m));

    s2p16_deser #(.MSB_FIRST(1'b0), .WIDTH(16)) u_lsb (
        .CK(CK), .RSTN(RSTN), .SDI(SDI), .SVALID(SVALID), .SYNC(SYNC),
        .WORD(word_l), .WVALID(wvalid_l), .FERR(ferr_l), .BUSY(busy_l));

    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: received bits of the current word, in arrival order.
    bit          mdl_busy;
    bit          mdl_ferr;
    bit          mdl_wv;
    bit          bits[$];
    logic [15:0] mdl_word_m, mdl_word_l;

    int          pulse_cyc[$];
    logic [15:0] pulse_word[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] compose(input bit msb);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (msb) w[15 - i] = bits[i];
            else     w[i]      = bits[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        mdl_busy   = 0;
        mdl_ferr   = 0;
        mdl_wv     = 0;
        bits.delete();
        mdl_word_m = '0;
        mdl_word_l = '0;
    endtask

    task automatic model_edge(input bit v, input bit s, input bit d);
        mdl_wv = 0;
        if (v) begin
            if (s) begin
                if (mdl_busy) mdl_ferr = 1;
                bits.delete();
                bits.push_back(d);
                mdl_busy = 1;
            end else if (mdl_busy) begin
                bits.push_back(d);
                if (bits.size() == 16) begin
                    mdl_word_m = compose(1'b1);
                    mdl_word_l = compose(1'b0);
                    mdl_wv     = 1;
                    mdl_busy   = 0;
                    bits.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        check("word_msb",   word_m,   mdl_word_m);
        check("wvalid_msb", wvalid_m, mdl_wv);
        check("ferr_msb",   ferr_m,   mdl_ferr);
        check("busy_msb",   busy_m,   mdl_busy);
        check("word_lsb",   word_l,   mdl_word_l);
        check("wvalid_lsb", wvalid_l, mdl_wv);
        check("ferr_lsb",   ferr_l,   mdl_ferr);
        check("busy_lsb",   busy_l,   mdl_busy);
    endtask

    task automatic step(input bit v, input bit s, input bit d);
        @(negedge CK);
        SVALID = v;
        SYNC   = s;
        SDI    = d;
        model_edge(v, s, d);
        @(posedge CK);
        #1;
        cyc++;
        compare_all();
        if (wvalid_m) begin
            pulse_cyc.push_back(cyc);
            pulse_word.push_back(word_m);
        end
    endtask

    task automatic gap_step();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_word(input logic [15:0] w, input bit msb_order, input int gap_pct);
        for (int i = 0; i < 16; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                gap_step();
            step(1'b1, i == 0, msb_order ? w[15 - i] : w[i]);
        end
    endtask

    task automatic clear_pulses();
        pulse_cyc.delete();
        pulse_word.delete();
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        @(negedge CK);
        RSTN = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Contiguous MSB-first word.
        clear_pulses();
        send_word(16'hA5C3, 1'b1, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("a5c3_word", word_m, 16'hA5C3);
        check("a5c3_pulses", pulse_cyc.size(), 1);
        check("a5c3_ferr", ferr_m, 1'b0);

        // Gapped input with SDI/SYNC toggling while SVALID is low.
        clear_pulses();
        send_word(16'h1234, 1'b1, 30);
        repeat (3) gap_step();
        check("gap_word", word_m, 16'h1234);
        check("gap_pulses", pulse_cyc.size(), 1);

        // Premature SYNC after 9 bits.
        clear_pulses();
        for (int i = 0; i < 9; i++)
            step(1'b1, i == 0, 1'($urandom_range(0, 1)));
        send_word(16'hBEEF, 1'b1, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("beef_word", word_m, 16'hBEEF);
        check("beef_pulses", pulse_cyc.size(), 1);
        check("beef_ferr_sticky", ferr_m, 1'b1);

        // Asynchronous reset mid-word at count 7.
        for (int i = 0; i < 7; i++)
            step(1'b1, i == 0, 1'($urandom_range(0, 1)));
        #2;
        SVALID = 1'b0;
        RSTN   = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge CK);
        RSTN = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Hunting, then two back-to-back words.
        clear_pulses();
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check("hunt_busy", busy_m, 1'b0);
        send_word(16'hFFFF, 1'b1, 0);
        send_word(16'h0001, 1'b1, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("b2b_pulses", pulse_cyc.size(), 2);
        check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 16);
        check("b2b_first", pulse_word[0], 16'hFFFF);
        check("b2b_second", word_m, 16'h0001);
        check("b2b_ferr", ferr_m, 1'b0);

        // LSB-first build: 8001 sent LSB-first.
        send_word(16'h8001, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
        check("lsb_word", word_l, 16'h8001);
        check("lsb_first_bit", word_l[0], 1'b1);

        // Random framed traffic.
        for (int i = 0; i < 400; i++)
            step(int'($urandom_range(0, 99)) < 80, int'($urandom_range(0, 99)) < 5,
                 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/s2p16_deser.md
Name: s2p16_deser

Overview:
Serial-to-parallel deserializer that sits directly upstream of the 16-bit parallel capture register. It assembles a framed serial bitstream into 16-bit words and presents each complete word on a held parallel bus with a one-cycle strobe. The downstream register is always enabled and samples the bus every CK edge, so the word bus changes only when a new word completes. A framing-error flag reports words broken by a premature SYNC.

Parameters:
MSB_FIRST, 1, 1 = first received bit lands in WORD[15]; 0 = first bit lands in WORD[0]
WIDTH, 16, word width; this block is specified and verified at 16 only

Ports:
CK  input  1  clock; all state updates on rising edge
RSTN  input  1  asynchronous active-low reset
SDI  input  1  serial data bit, sampled when SVALID=1
SVALID  input  1  qualifies SDI on this CK edge
SYNC  input  1  start-of-word marker; valid only together with SVALID=1
WORD  output  16  last completed word, held stable between completions
WVALID  output  1  one-cycle pulse, high the cycle after a word completes
FERR  output  1  sticky framing error; cleared only by reset
BUSY  output  1  high while a word is partially assembled

Behaviour:
- Reset (RSTN=0, asynchronous): WORD=16'h0000, WVALID=0, FERR=0, BUSY=0, shift register=0, bit counter=0, state=IDLE.
- Deassertion of RSTN takes effect at the next CK edge; no capture on the release edge itself.
- Cycles with SVALID=0: no state change; SDI and SYNC are ignored. WVALID drops to 0 if it was high.
- State IDLE:
  - SVALID=1, SYNC=1: shift in SDI as bit 0 of the word, count=1, go to SHIFT.
  - SVALID=1, SYNC=0: bit discarded, stay in IDLE. This is hunting, not an error.
- State SHIFT:
  - SVALID=1, SYNC=0: shift in SDI and increment count.
  - On the 16th bit (count 15 -> 16): load WORD from the shift register including this bit, pulse WVALID the next cycle, reset count to 0, go to IDLE.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters LSB. The first bit ends in WORD[15].
  - MSB_FIRST=0: shift right, new bit enters MSB. The first bit ends in WORD[0].
- SYNC=1 with SVALID=1 while in SHIFT (premature SYNC):
  - Partial word is discarded and FERR is set.
  - The current bit starts a new word: count=1, stay in SHIFT.
  - WORD is unchanged and WVALID is not pulsed.
- Latency: WORD and WVALID update at the CK edge that samples the 16th bit, so both are visible one cycle after that bit is presented.
- WORD holds its value until the next completed word; partial assembly never disturbs it.
- Back-to-back words: a SYNC on the cycle immediately after completion starts the next word. WVALID pulses are then at least 16 SVALID cycles apart.
- BUSY = (state==SHIFT). It is low in the cycle WVALID is high unless a new SYNC was accepted on that same edge.
- Counter is 5 bits and never exceeds 16; no wrap beyond a word.
- No backpressure: the consumer samples every cycle, and words are never dropped or stalled.

Test Plan:
- Reset: drive RSTN=0 mid-word (count=7) asynchronously between edges -> WORD=0000, WVALID=0, BUSY=0, FERR=0 immediately. A fresh SYNC word after release assembles correctly.
- MSB_FIRST=1: SYNC with SVALID on bit 0, then 16 contiguous bits of 16'hA5C3 MSB-first -> WORD=A5C3 with a single WVALID pulse one cycle after the 16th bit; FERR=0.
- Gapped input: same word 16'h1234 with SVALID low on a random ~30% of cycles and SDI toggling during gaps -> WORD=1234, exactly one WVALID; BUSY high from the first bit until completion.
- Premature SYNC: send 9 bits of a word, then SYNC plus 16 bits of 16'hBEEF -> FERR=1 (sticky), WORD=BEEF, exactly one WVALID. WORD does not change at the premature SYNC.
- Hunting and back-to-back: 5 bits with SYNC=0 in IDLE, then words 16'hFFFF and 16'h0001 with no idle gap -> two WVALID pulses 16 cycles apart, WORD=FFFF then 0001, FERR=0.
- MSB_FIRST=0 build: 16 bits of 16'h8001 sent LSB-first -> WORD=8001; first bit observed in WORD[0].
